pp_accumulator: RTL and testbench
=================================

# pp_accumulator

- Sequential reduction stage that sits directly downstream of the 6x6 partial-product generator.
- Accepts one set of six 6-bit partial products (p1..p6) per transaction over a valid/ready handshake.
- Adds them with their binary weights over successive cycles and returns the 12-bit unsigned product over a second valid/ready handshake.
- Trades throughput for area: one 12-bit adder is reused for all six partial products.

## Interface
Parameters:
- none (widths are fixed at 6-bit partial products and a 12-bit product)

Ports:
- clk  input  1  — rising-edge clock; the only clock.
- rst  input  1  — asynchronous, active-high reset.
- in_valid  input  1  — p1..p6 hold a valid set.
- in_ready  output  1  — block can accept a set; high only in IDLE.
- p1..p6  input  6 each  — partial products; pk carries weight 2^(k-1).
- out_valid  output  1  — product is valid; high only in DONE.
- out_ready  input  1  — consumer accepts product.
- product  output  12  — accumulated result.
- busy  output  1  — high when state is not IDLE.

## Operation
Registers:
- pp[0..5], 6 bits each
- acc, 12 bits
- cnt, 3 bits
- state: IDLE, ACCUM, DONE

States and transitions:
- **IDLE:**
  - in_ready=1.
  - On in_valid&&in_ready: capture pp[k]=p(k+1), acc=0, cnt=0, go to ACCUM.
- **ACCUM:**
  - Each cycle: acc <= acc + (pp[cnt] << cnt), cnt <= cnt+1.
  - After the cycle with cnt==5, go to DONE (default build).
- **DONE:**
  - out_valid=1.
  - On out_ready, go to IDLE.

Output rules:
- product is driven directly from acc.
- product holds the last result after the output handshake, until the next capture clears acc.

Arithmetic:
- Unsigned, zero-extended, 12-bit.
- Maximum sum is 63·(1+2+…+32) = 3969, so no overflow is possible.

Boundary conditions:
- in_valid while busy is ignored; inputs are not sampled outside IDLE.
- out_ready while out_valid=0 is ignored.
- Consumer stall: DONE persists indefinitely; out_valid and product stay stable.
- rst in any state:
  - Immediately returns to IDLE.
  - Clears acc, cnt and pp[*].
  - Any in-flight transaction is discarded, with no out_valid.
- Reset values:
  - in_ready=1
  - out_valid=0
  - busy=0
  - product=0

## Timing
- Accept edge is E0, the edge where in_valid&&in_ready.
- ACCUM occupies edges E1..E6.
- out_valid rises after E6, i.e. 6 cycles after acceptance (default build).
- With out_ready held high:
  - DONE→IDLE occurs at E7.
  - The next accept is possible at E8.
  - Sustained throughput is one result per 8 cycles.
- in_ready and out_valid are decoded from the state register only; there is no combinational path from in_valid or out_ready.
- busy rises the cycle after acceptance and falls the cycle after the output handshake.

## Configuration
- Macro: PPACC_SKIP_ZERO_EN.
- **Defined:**
  - In ACCUM, after adding pp[cnt], go to DONE if cnt==5 or pp[k]==0 for every k>cnt.
  - Latency becomes 1 + index of the highest nonzero partial product.
  - Minimum latency is 1 cycle, including an all-zero input.
  - The result is identical to the default build.
- **Undefined:** fixed 6-cycle ACCUM regardless of data.

## Test plan
- **All maximum:** p1..p6=63, out_ready=1.
  - product=3969.
  - out_valid rises 6 cycles after accept in both builds; with skip-zero it is still 6, because p6 is nonzero.
- **A=5, B=3:** p1=5, p2=5, p3..p6=0.
  - product=15.
  - Latency 6 by default; 2 with PPACC_SKIP_ZERO_EN.
- **Backpressure:** out_ready=0 for 10 cycles after out_valid, with new p values and in_valid=1 applied meanwhile.
  - product stays constant at the old result.
  - in_ready=0, and the new inputs are not captured.
  - Releasing out_ready returns the block to IDLE on the next edge.
- **Reset mid-operation:** assert rst while cnt==3.
  - Immediately: out_valid=0, in_ready=1, product=0, busy=0.
  - No result emerges for the aborted transaction.
- **All zero inputs:**
  - product=0.
  - Latency 6 by default, 1 with the macro.
- **Back-to-back, in_valid held high:** two sets, p1=1 only and then p6=1 only.
  - Products are 1, then 32.
  - Accept edges are 8 cycles apart (default build).

Source files
------------

// File: rtl/pp_accumulator.sv
// Sequential 6x6 partial-product accumulator: one shared 12-bit adder sums p1..p6 with binary weights.
// Optional early termination on all-zero upper partial products: define PPACC_SKIP_ZERO_EN.
module pp_accumulator (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  p1,
  input  logic [5:0]  p2,
  input  logic [5:0]  p3,
  input  logic [5:0]  p4,
  input  logic [5:0]  p5,
  input  logic [5:0]  p6,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [5:0]  pp_reg [6];
  logic [5:0]  p_in [6];
  logic [11:0] acc_reg;
  logic [2:0]  cnt_reg;
  logic [5:0]  sel_pp;
  logic [11:0] addend;
  logic        last_step;
  logic        accept;

  assign p_in[0] = p1;
  assign p_in[1] = p2;
  assign p_in[2] = p3;
  assign p_in[3] = p4;
  assign p_in[4] = p5;
  assign p_in[5] = p6;

  assign accept = in_valid && (state_reg == IDLE);

  always_comb begin
    sel_pp = 6'd0;
    case (cnt_reg)
      3'd0:    sel_pp = pp_reg[0];
      3'd1:    sel_pp = pp_reg[1];
      3'd2:    sel_pp = pp_reg[2];
      3'd3:    sel_pp = pp_reg[3];
      3'd4:    sel_pp = pp_reg[4];
      3'd5:    sel_pp = pp_reg[5];
      default: sel_pp = 6'd0;
    endcase
  end

  assign addend = {6'd0, sel_pp} << cnt_reg;

`ifdef PPACC_SKIP_ZERO_EN
  logic [5:0] nonzero;
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_nonzero
      assign nonzero[gi] = |pp_reg[gi];
    end
  endgenerate
  // Stop once every partial product above the current index is zero.
  assign last_step = (cnt_reg == 3'd5) ||
                     ((nonzero >> ({1'b0, cnt_reg} + 4'd1)) == 6'd0);
`else
  assign last_step = (cnt_reg == 3'd5);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = ACCUM;
      ACCUM:   if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) pp_reg[k] <= 6'd0;
      acc_reg <= 12'd0;
      cnt_reg <= 3'd0;
    end else if (accept) begin
      for (int k = 0; k < 6; k++) pp_reg[k] <= p_in[k];
      acc_reg <= 12'd0;
      cnt_reg <= 3'd0;
    end else if (state_reg == ACCUM) begin
      acc_reg <= acc_reg + addend;
      cnt_reg <= cnt_reg + 3'd1;
    end
  end

  // acc is left untouched after the handshake so the result stays visible.
  assign product = acc_reg;

endmodule

// File: tb/tb_pp_accumulator.sv
// Self-checking bench for pp_accumulator with a product scoreboard queue.
// Expected latencies follow PPACC_SKIP_ZERO_EN when the bench is built with it.
module tb_pp_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  p1, p2, p3, p4, p5, p6;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pp_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  function automatic int model_product(input logic [35:0] v);
    int s = 0;
    for (int k = 0; k < 6; k++) s += int'(v[6*k +: 6]) * (1 << k);
    return s;
  endfunction

  function automatic int model_latency(input logic [35:0] v);
`ifdef PPACC_SKIP_ZERO_EN
    int hi = 0;
    for (int k = 0; k < 6; k++) if (v[6*k +: 6] != 6'd0) hi = k;
    return hi + 1;
`else
    return (v === 36'bx) ? 0 : 6;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input logic [35:0] v);
    p1 = v[5:0];   p2 = v[11:6];  p3 = v[17:12];
    p4 = v[23:18]; p5 = v[29:24]; p6 = v[35:30];
  endtask

  // Accept one set from IDLE and wait (bounded) for out_valid; lat = cycles after accept.
  task automatic send_and_wait(input logic [35:0] v, output int lat);
    set_p(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model_product(v));
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; set_p(36'd0);
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || product !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready/out_valid/busy=%b product=%0d, required 100 and 0",
               {in_ready, out_valid, busy}, product);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    $display("reset: in_ready=%b out_valid=%b busy=%b product=%0d", in_ready, out_valid, busy, product);
  endtask

  task automatic test_single(input string name, input logic [35:0] v);
    int lat, exp_p;
    send_and_wait(v, lat);
    exp_p = exp_q.pop_front();
    checks++;
    if (lat != model_latency(v)) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, model_latency(v));
    end
    checks++;
    if (product !== 12'(exp_p) || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_product: product=%0d busy=%b in_ready=%b, required %0d 1 0",
               name, product, busy, in_ready, exp_p);
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || product !== 12'(exp_p)) begin
      errors++;
      $display("FAIL %s_after_handshake: in_ready=%b busy=%b out_valid=%b product=%0d, required 1 0 0 %0d",
               name, in_ready, busy, out_valid, product, exp_p);
    end
    $display("%s: latency=%0d product=%0d expected=%0d", name, lat, product, exp_p);
  endtask

  task automatic test_all_max;
    test_single("all_max", {6{6'd63}});
    checks++;
    if (product !== 12'd3969) begin
      errors++;
      $display("FAIL all_max_const: product=%0d, required 3969", product);
    end
  endtask

  task automatic test_backpressure;
    int lat, exp_p;
    send_and_wait({24'd0, 6'd5, 6'd5}, lat);
    exp_p = exp_q.pop_front();
    set_p({6{6'd63}});
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (product !== 12'(exp_p) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_stall%0d: product=%0d out_valid=%b in_ready=%b, required %0d 1 0",
                 i, product, out_valid, in_ready, exp_p);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 12'(exp_p)) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b product=%0d, required 1 0 %0d",
               in_ready, out_valid, product, exp_p);
    end
    $display("backpressure: held product=%0d for 10 cycles, released to IDLE", product);
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    set_p({6{6'd63}});
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model_product({6{6'd63}}));
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 12'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_immediate: out_valid=%b in_ready=%b product=%0d busy=%b, required 0 1 0 0",
               out_valid, in_ready, product, busy);
    end
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || product !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_no_result: out_valid seen %0d cycles product=%0d, required 0 and 0", seen, product);
    end
    $display("reset_mid: aborted at cnt==3, no result emerged");
  endtask

  task automatic test_back_to_back;
    logic [35:0] v1 = {30'd0, 6'd1};
    logic [35:0] v2 = {6'd1, 30'd0};
    logic [35:0] cur;
    int n_acc = 0, n_out = 0, cyc = 0, a0 = 0, a1 = 0, exp_p;
    bit acc_now, out_now;
    cur = v1;
    set_p(v1);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (n_out < 2 && cyc < 60) begin
      acc_now = (in_valid === 1'b1) && (in_ready === 1'b1);
      out_now = (out_valid === 1'b1) && (out_ready === 1'b1);
      if (out_now) begin
        exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (product !== 12'(exp_p)) begin
          errors++;
          $display("FAIL b2b_product%0d: product=%0d, required %0d", n_out, product, exp_p);
        end
        $display("b2b: result %0d product=%0d expected=%0d", n_out, product, exp_p);
        n_out++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        exp_q.push_back(model_product(cur));
        if (n_acc == 0) begin
          a0 = cyc;
          cur = v2;
          set_p(v2);
        end else begin
          a1 = cyc;
          in_valid = 1'b0;
        end
        n_acc++;
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (n_out != 2 || n_acc != 2) begin
      errors++;
      $display("FAIL b2b_timeout: accepts=%0d results=%0d, required 2 2", n_acc, n_out);
    end
    checks++;
    if (a1 - a0 != model_latency(v1) + 2) begin
      errors++;
      $display("FAIL b2b_spacing: accept edges %0d apart, required %0d", a1 - a0, model_latency(v1) + 2);
    end
    $display("b2b: accept spacing=%0d cycles", a1 - a0);
  endtask

  task automatic test_random;
    logic [35:0] v;
    for (int i = 0; i < 4; i++) begin
      v = {$urandom(), $urandom()};
      if (i == 1) v[35:18] = 18'd0;
      test_single($sformatf("random%0d", i), v);
    end
  endtask

  initial begin
    test_reset();
    test_all_max();
    test_single("a5_b3", {24'd0, 6'd5, 6'd5});
    test_single("all_zero", 36'd0);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
